// File: rtl/shift_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_window_pkg
// Description : Shared types and helpers for the shift-window controller.
//               - state_t     : controller states (IDLE / FILL / FULL)
//               - MODE_*      : windowing mode encodings
//               - word_w()    : index word width from SAMPLES and OSF
// Revision    : 1.0 - initial release
// ============================================================================
package shift_window_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic MODE_SLIDE = 1'b0;
  localparam logic MODE_BLOCK = 1'b1;

  // Index words span 0..SAMPLES*OSF-1 plus one extra bit of headroom.
  function automatic int word_w(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : window_shift_reg
// Description : DEPTH-word shift register. New words enter at the low end;
//               the top word is the oldest.
// Ports       : Clk      - clock
//               clear    - synchronous clear to zero (priority over shift)
//               shift_en - shift din in this cycle
//               din      - incoming word (WIDTH bits)
//               dout     - full register contents (DEPTH*WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module window_shift_reg #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   clear,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       din,
  output logic [DEPTH*WIDTH-1:0] dout
);

  logic [DEPTH*WIDTH-1:0] win;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge Clk) begin
        if (clear) begin
          win <= '0;
        end else if (shift_en) begin
          win <= din;
        end
      end
    end else begin : g_multi
      always_ff @(posedge Clk) begin
        if (clear) begin
          win <= '0;
        end else if (shift_en) begin
          win <= {win[(DEPTH-1)*WIDTH-1:0], din};
        end
      end
    end
  endgenerate

  assign dout = win;

endmodule
`default_nettype wire

// File: rtl/shift_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_window_ctrl
// Description : Gathers index words into an n-word window and presents each
//               complete window to a consumer. Sliding mode presents a new
//               window per accepted word once filled; block mode presents
//               non-overlapping windows. Also counts SAMPLES-word frames.
// Ports       : Clk, Reset   - clock, synchronous active-high reset
//               Flush        - synchronous clear; reloads mode from Mode
//               Mode         - 0 sliding, 1 block (sampled while IDLE)
//               InValid/InData/InReady    - word input handshake
//               WinValid/WinData/WinReady - window output handshake
//               FrameEnd     - pulse after the SAMPLES-th word of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module shift_window_ctrl
  import shift_window_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int n       = 4
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  Flush,
  input  logic                                  Mode,
  input  logic                                  InValid,
  input  logic [word_w(SAMPLES, OSF)-1:0]       InData,
  output logic                                  InReady,
  output logic                                  WinValid,
  output logic [n*word_w(SAMPLES, OSF)-1:0]     WinData,
  input  logic                                  WinReady,
  output logic                                  FrameEnd
);

  localparam int W  = word_w(SAMPLES, OSF);
  localparam int CW = $clog2(n + 1);
  localparam int FW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  localparam logic [CW-1:0] FILL_MAX   = CW'(n);
  localparam logic [CW-1:0] FILL_LAST  = CW'(n - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SAMPLES - 1);

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  fill_cnt;
  logic [CW-1:0]  fill_nxt;
  logic           mode_q;
  logic [FW-1:0]  frame_cnt;
  logic           frame_end;
  logic           clr;
  logic           acc;
  logic           take;

  assign clr  = Reset | Flush;
  assign acc  = InValid & InReady;
  assign take = WinValid & WinReady;

  window_shift_reg #(
    .WIDTH (W),
    .DEPTH (n)
  ) u_window (
    .Clk      (Clk),
    .clear    (clr),
    .shift_en (acc),
    .din      (InData),
    .dout     (WinData)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (clr) begin
      state    <= IDLE;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  // Mode may only change between windows, i.e. while nothing is buffered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q <= MODE_SLIDE;
    end else if (Flush || state == IDLE) begin
      mode_q <= Mode;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    case (state)
      IDLE: begin
        if (acc) begin
          fill_nxt  = CW'(1);
          state_nxt = (n == 1) ? FULL : FILL;
        end
      end
      FILL: begin
        if (acc) begin
          fill_nxt = fill_cnt + CW'(1);
          if (fill_cnt + CW'(1) == FILL_MAX) begin
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (take) begin
          if (mode_q == MODE_BLOCK) begin
            fill_nxt  = '0;
            state_nxt = IDLE;
          end else if (!acc) begin
            // Sliding with no replacement word: the newest n-1 words are
            // kept and one more word completes the next window.
            fill_nxt  = FILL_LAST;
            state_nxt = (n == 1) ? IDLE : FILL;
          end
        end
      end
      default: begin
        fill_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic. In sliding mode a word can enter in the same cycle the
  // held window is taken, which makes InReady combinational on WinReady.
  always_comb begin
    WinValid = (state == FULL);
    InReady  = (state != FULL) | (WinReady & (mode_q == MODE_SLIDE));
  end

  // Frame counter runs on every accepted word regardless of window state.
  always_ff @(posedge Clk) begin
    if (clr) begin
      frame_cnt <= '0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      if (acc) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          frame_end <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  assign FrameEnd = frame_end;

endmodule
`default_nettype wire

// File: tb/tb_shift_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_window_ctrl
// Description : Self-checking bench for shift_window_ctrl. A behavioural
//               model tracks accepted words, taken windows and the frame
//               count; a compare process checks every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_window_ctrl;

  localparam int SAMPLES = 128;
  localparam int OSF     = 8;
  localparam int N       = 4;
  localparam int W       = 11;

  logic           Clk = 1'b0;
  logic           Reset, Flush, Mode, InValid, InReady;
  logic           WinValid, WinReady, FrameEnd;
  logic [W-1:0]   InData;
  logic [N*W-1:0] WinData;

  int n_cmp = 0;
  int n_bad = 0;

  shift_window_ctrl #(
    .SAMPLES (SAMPLES),
    .OSF     (OSF),
    .n       (N)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Flush    (Flush),
    .Mode     (Mode),
    .InValid  (InValid),
    .InData   (InData),
    .InReady  (InReady),
    .WinValid (WinValid),
    .WinData  (WinData),
    .WinReady (WinReady),
    .FrameEnd (FrameEnd)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sliding: a window exists once N words have arrived and the window made
  // of the latest word has not been taken yet. Block: a window exists once N
  // words have arrived since the last taken block.
  bit           m_init = 1'b0;
  bit           m_mode;
  int           m_tot, m_taken, m_blk, m_fcnt;
  bit           m_fe;
  logic [W-1:0] m_win [N];

  function automatic bit m_valid();
    return m_mode ? (m_blk == N) : (m_tot >= N && m_taken != m_tot);
  endfunction

  function automatic bit m_ready(input bit wr);
    return !m_valid() || (wr && !m_mode);
  endfunction

  task automatic m_clear(input bit md);
    m_mode = md; m_tot = 0; m_taken = 0; m_blk = 0; m_fcnt = 0; m_fe = 1'b0;
    for (int i = 0; i < N; i++) m_win[i] = '0;
  endtask

  always @(posedge Clk) begin
    bit v, a, t;
    if (Reset) begin
      m_clear(1'b0);
      m_init = 1'b1;
    end else if (Flush) begin
      m_clear(Mode);
    end else if (m_init) begin
      v = m_valid();
      a = InValid && m_ready(WinReady);
      t = v && WinReady;
      m_fe = 1'b0;
      if (t) begin
        if (m_mode) m_blk = 0;
        else        m_taken = m_tot;
      end
      if (a) begin
        m_tot++;
        m_blk++;
        for (int i = N - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = InData;
        if (m_fcnt == SAMPLES - 1) begin
          m_fcnt = 0;
          m_fe   = 1'b1;
        end else begin
          m_fcnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    logic [N*W-1:0] ew;
    if (m_init) begin
      for (int i = 0; i < N; i++) ew[i*W +: W] = m_win[i];
      chk("InReady",  64'(InReady),  64'(m_ready(WinReady)));
      chk("WinValid", 64'(WinValid), 64'(m_valid()));
      chk("WinData",  64'(WinData),  64'(ew));
      chk("FrameEnd", 64'(FrameEnd), 64'(m_fe));
    end
  end

  // ---------------- directed observation ----------------
  logic [N*W-1:0] got[$];
  int             fe_cnt = 0;

  always @(negedge Clk) begin
    if (WinValid && WinReady) got.push_back(WinData);
    if (FrameEnd) fe_cnt++;
  end

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(a), W'(b), W'(c), W'(d)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input int v);
    int guard;
    bit ok;
    InValid = 1'b1;
    InData  = W'(v);
    guard   = 0;
    do begin
      @(negedge Clk);
      ok = InReady;
      @(posedge Clk); #1;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0d not accepted, required within 50 cycles", v);
    end
  endtask

  task automatic idle(input int k);
    InValid = 1'b0;
    repeat (k) begin @(posedge Clk); #1; end
  endtask

  task automatic do_flush(input bit md);
    InValid = 1'b0;
    Flush   = 1'b1;
    Mode    = md;
    @(posedge Clk); #1;
    Flush   = 1'b0;
  endtask

  initial begin
    bit pend, ok;
    int r;
    Reset = 1'b1; Flush = 1'b0; Mode = 1'b0;
    InValid = 1'b0; InData = '0; WinReady = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;

    // Reset state
    @(negedge Clk);
    chk("rst_WinValid", 64'(WinValid), 64'd0);
    chk("rst_WinData",  64'(WinData),  64'd0);
    chk("rst_InReady",  64'(InReady),  64'd1);
    chk("rst_FrameEnd", 64'(FrameEnd), 64'd0);
    @(posedge Clk); #1;

    // Fill, sliding, no consumer
    WinReady = 1'b0;
    for (int v = 1; v <= 4; v++) send(v);
    InValid = 1'b0;
    @(negedge Clk);
    chk("fill_WinValid", 64'(WinValid), 64'd1);
    chk("fill_WinData",  64'(WinData),  64'(pk(1, 2, 3, 4)));
    chk("fill_InReady",  64'(InReady),  64'd0);
    @(posedge Clk); #1;

    // Backpressure: word 5 held for 5 cycles, then taken with the window
    InValid = 1'b1;
    InData  = W'(5);
    repeat (5) begin
      @(negedge Clk);
      chk("bp_WinData", 64'(WinData), 64'(pk(1, 2, 3, 4)));
      @(posedge Clk); #1;
    end
    WinReady = 1'b1;
    send(5);
    InValid  = 1'b0;
    WinReady = 1'b0;
    @(negedge Clk);
    chk("bp_next_WinData", 64'(WinData), 64'(pk(2, 3, 4, 5)));
    @(posedge Clk); #1;

    // Sliding stream
    do_flush(1'b0);
    got.delete();
    WinReady = 1'b1;
    for (int v = 1; v <= 6; v++) send(v);
    idle(3);
    chk("slide_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("slide_w0", 64'(got[0]), 64'(pk(1, 2, 3, 4)));
      chk("slide_w1", 64'(got[1]), 64'(pk(2, 3, 4, 5)));
      chk("slide_w2", 64'(got[2]), 64'(pk(3, 4, 5, 6)));
    end

    // Block mode
    do_flush(1'b1);
    got.delete();
    WinReady = 1'b1;
    for (int v = 1; v <= 8; v++) send(v);
    idle(3);
    chk("block_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("block_w0", 64'(got[0]), 64'(pk(1, 2, 3, 4)));
      chk("block_w1", 64'(got[1]), 64'(pk(5, 6, 7, 8)));
    end

    // Flush mid-fill
    do_flush(1'b0);
    WinReady = 1'b1;
    send(7);
    send(8);
    do_flush(1'b0);
    @(negedge Clk);
    chk("flush_WinData", 64'(WinData), 64'd0);
    got.delete();
    @(posedge Clk); #1;
    for (int v = 9; v <= 12; v++) send(v);
    idle(3);
    chk("flush_count", 64'(got.size()), 64'd1);
    if (got.size() == 1) chk("flush_w0", 64'(got[0]), 64'(pk(9, 10, 11, 12)));

    // Frame end
    do_flush(1'b0);
    fe_cnt   = 0;
    WinReady = 1'b1;
    for (int i = 1; i <= 127; i++) send(i);
    chk("frame_early", 64'(fe_cnt), 64'd0);
    send(128);
    idle(2);
    chk("frame_first", 64'(fe_cnt), 64'd1);
    for (int i = 129; i <= 255; i++) send(i);
    chk("frame_mid", 64'(fe_cnt), 64'd1);
    send(256);
    idle(2);
    chk("frame_second", 64'(fe_cnt), 64'd2);

    // Randomized traffic with occasional flush/reset
    do_flush(1'b0);
    pend = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      Reset = 1'b0;
      Flush = 1'b0;
      if (!pend) begin
        InValid = ($urandom_range(0, 3) != 0);
        InData  = W'($urandom);
      end
      WinReady = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 299);
      if (r == 0) begin
        Reset = 1'b1;
        Mode  = 1'b0;
      end else if (r < 4) begin
        Flush = 1'b1;
        Mode  = 1'($urandom_range(0, 1));
      end
      @(negedge Clk);
      ok = InReady;
      @(posedge Clk); #1;
      pend = InValid && !ok;
    end
    Reset = 1'b0;
    Flush = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_window_ctrl.md
Name: shift_window_ctrl

Overview:
- Controller and sequencer for an n-word sample window of index words.
- Each word is $clog2(SAMPLES*OSF)+1 bits wide.
- Accepts index words over a valid/ready input and gates the shift-enable of an internal window register.
- Tracks the fill level and presents a complete n-word window to a downstream consumer over valid/ready, supporting sliding and block windowing.
- Sits between the per-sample index generator and the window consumer (peak/decision logic). It also counts frames of SAMPLES accepted words.

Parameters:
- SAMPLES, 128: accepted words per frame; sets index range and frame length.
- OSF, 8: oversampling factor; index word width is W = $clog2(SAMPLES*OSF)+1 (11 at defaults).
- n, 4: words per window; n >= 1; window width is n*W (44 at defaults).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- Flush  in  1  synchronous clear of window, fill state and frame counter.
- Mode  in  1  0 = sliding window, 1 = block window; honoured only in IDLE.
- InValid  in  1  InData is valid.
- InData  in  W  index word.
- InReady  out  1  controller can accept InData this cycle.
- WinValid  out  1  WinData holds a complete, unconsumed window.
- WinData  out  n*W  window; [W-1:0] is the newest word, the MSB word is the oldest.
- WinReady  in  1  consumer takes the window this cycle.
- FrameEnd  out  1  one-cycle pulse after the SAMPLES-th accepted word of a frame.

Behaviour:
- Definitions:
  - acc = InValid & InReady.
  - take = WinValid & WinReady.
- Reset and Flush:
  - State IDLE, fill_cnt = 0, window register = 0, frame counter = 0, mode_q = 0.
  - Outputs after reset: WinValid = 0, WinData = 0, FrameEnd = 0, InReady = 1.
  - Flush has the same effect as Reset, except mode_q is reloaded from Mode. It takes priority over acc/take in the same cycle.
  - Reset or Flush mid-window discards the partial window; no WinValid is produced for it.
- Shift:
  - On acc, window <= {window[(n-1)*W-1:0], InData}; for n = 1, window <= InData.
  - Shifted data is visible on WinData the next cycle.
  - The window register holds its value when acc = 0.
- State machine (fill_cnt 0..n):
  - IDLE (fill_cnt = 0):
    - mode_q <= Mode every cycle.
    - On acc: fill_cnt = 1, go to FILL, or to FULL if n = 1.
  - FILL (0 < fill_cnt < n):
    - On acc: fill_cnt++.
    - When fill_cnt reaches n, go to FULL.
  - FULL:
    - WinValid = 1; WinData is stable until take.
    - Sliding, take & acc: shift, stay FULL; the new window is valid next cycle.
    - Sliding, take only: fill_cnt = n-1, go to FILL (IDLE if n = 1). Each window is presented exactly once.
    - Block, on take: fill_cnt = 0, go to IDLE. The next window needs n fresh words with no overlap.
- InReady:
  - InReady = (state != FULL) | (WinReady & ~mode_q). This is a combinational WinReady -> InReady path, documented for integration.
  - In block mode, InReady = 0 while FULL.
- Latency:
  - The first window's WinValid rises the cycle after the n-th acc.
  - Back-to-back input with WinReady held at 1 gives one window per cycle in sliding mode. Block mode gives one window every n+1 cycles.
- Frame counter:
  - Counts acc from 0 to SAMPLES-1 and wraps to 0.
  - FrameEnd is a registered pulse in the cycle after the acc that wraps the counter.
  - The frame counter is independent of window state and is not cleared by take.
- Simultaneous events:
  - InValid with InReady = 0: the word is not consumed and the producer must hold it.
  - WinValid must not drop without take, except on Reset or Flush.

Decomposition:
- Package shift_window_pkg:
  - state typedef: IDLE, FILL, FULL.
  - Width helper function word_w(SAMPLES, OSF) = $clog2(SAMPLES*OSF)+1.
  - Constants MODE_SLIDE = 0 and MODE_BLOCK = 1.
- One sub-module, window_shift_reg:
  - n-word shift register with shift-enable and synchronous clear.
  - The controller drives its enable from acc and its clear from Reset | Flush.
- FSM, fill counter, frame counter and handshake logic stay in shift_window_ctrl.

Test Plan:
- Fill: after Reset, sliding mode, WinReady = 0, send 1, 2, 3, 4 on consecutive cycles.
  - WinValid rises the cycle after 4, with WinData = {11'd1, 11'd2, 11'd3, 11'd4}.
  - InReady = 0 while held.
- Sliding stream: WinReady = 1, stream 1..6.
  - Windows are {1,2,3,4}, {2,3,4,5}, {3,4,5,6} on consecutive cycles; no window is repeated.
- Block mode: Mode = 1, WinReady = 1, stream 1..8 continuously.
  - Exactly two windows appear: {1,2,3,4} and {5,6,7,8}.
  - InReady = 0 during each FULL cycle.
- Flush mid-fill: send 7, 8, then assert Flush, then send 9, 10, 11, 12.
  - The only window is {9,10,11,12}.
  - WinData = 0 in the cycle after Flush.
- Frame end: 128 accepted words with WinReady = 1.
  - FrameEnd pulses once, in the cycle after word 128.
  - Word 129 starts a new frame; the next pulse comes after word 256.
- Backpressure: in FULL, hold WinReady = 0 for 5 cycles with InValid = 1.
  - WinData is unchanged, no word is lost, and the next window includes the held word.
